// File: rtl/lcg_shift_mult_ctrl.sv
// Shift-and-add sequencer for one LCG step x_next = a*x + c (mod 2^W) on a shared
// left barrel shifter; one shifter pass per set bit of a, lowest bit first.
module lcg_shift_mult_ctrl #(
    parameter int unsigned W  = 64,
    parameter int unsigned SW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          seed_load,
    input  logic [W-1:0]  seed,
    input  logic [W-1:0]  mult_a,
    input  logic [W-1:0]  incr_c,
    output logic [W-1:0]  sh_in,
    output logic [SW-1:0] sh_amt,
    input  logic [W-1:0]  sh_out,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  rand_out
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   x_q, acc_q, a_rem_q, rand_q;
    logic [W-1:0]   sum, a_rem_nxt;
    logic [SW-1:0]  k;
    logic           last;

    // Priority encoder: index of the lowest set bit of the remaining multiplier.
    always_comb begin
        k = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (a_rem_q[i]) k = SW'(i);
        end
    end

    assign sum       = acc_q + sh_out;
    assign a_rem_nxt = a_rem_q & (a_rem_q - W'(1));
    assign last      = (a_rem_nxt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = (mult_a == '0) ? StDone : StScan;
            end
            StScan: begin
                if (last) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        sh_amt = '0;
        sh_in  = x_q;
        case (state_q)
            StIdle: begin
                // A seed loaded on the start edge is the operand of this step.
                if (start && seed_load) sh_in = seed;
            end
            StScan: begin
                busy   = 1'b1;
                sh_amt = k;
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            acc_q   <= '0;
            a_rem_q <= '0;
            rand_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (seed_load) x_q <= seed;
                    if (start) begin
                        a_rem_q <= mult_a;
                        acc_q   <= incr_c;
                        if (mult_a == '0) begin
                            rand_q <= incr_c;
                            x_q    <= incr_c;
                        end
                    end
                end
                StScan: begin
                    acc_q   <= sum;
                    a_rem_q <= a_rem_nxt;
                    if (last) begin
                        rand_q <= sum;
                        x_q    <= sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rand_out = rand_q;

endmodule

// File: tb/tb_lcg_shift_mult_ctrl.sv
// Bench for lcg_shift_mult_ctrl: table-driven LCG steps, random steps against an
// arithmetic model, plus busy-input and mid-step reset sequences.
module tb_lcg_shift_mult_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, seed_load;
    logic [63:0] seed, mult_a, incr_c;
    logic [63:0] sh_in, sh_out, rand_out;
    logic [5:0]  sh_amt;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] x_m;  // model of generator state

    always #5 clk = ~clk;

    // Ideal shifter
    assign sh_out = sh_in << sh_amt;

    lcg_shift_mult_ctrl #(.W(64), .SW(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .seed_load (seed_load),
        .seed      (seed),
        .mult_a    (mult_a),
        .incr_c    (incr_c),
        .sh_in     (sh_in),
        .sh_amt    (sh_amt),
        .sh_out    (sh_out),
        .busy      (busy),
        .done      (done),
        .rand_out  (rand_out)
    );

    typedef struct {
        logic        do_seed;
        logic [63:0] seed;
        logic [63:0] a;
        logic [63:0] c;
        logic [63:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_rand"}, rand_out, 64'd0);
        chk({tag, "_shamt"}, 64'(sh_amt), 64'd0);
        chk({tag, "_shin"}, sh_in, 64'd0);
    endtask

    // One LCG step with cycle-exact checks. disturb: SCAN cycle index at which start and
    // seed_load are pulsed; abort_at: SCAN cycle index at which reset is asserted.
    task automatic do_step(input logic sl, input logic [63:0] sd, input logic [63:0] a,
                           input logic [63:0] c, input logic [63:0] exp,
                           input int disturb, input int abort_at);
        logic [63:0] xu;
        int n;
        xu = sl ? sd : x_m;
        @(negedge clk);
        start = 1'b1; seed_load = sl; seed = sd; mult_a = a; incr_c = c;
        #1;
        chk("idle_shin", sh_in, xu);
        chk("idle_shamt", 64'(sh_amt), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0; seed_load = 1'b0;
        mult_a = {$urandom, $urandom}; incr_c = {$urandom, $urandom}; seed = {$urandom, $urandom};
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (a[i]) begin
                @(negedge clk);
                if (n == abort_at) begin
                    reset = 1'b1;
                    #1;
                    chk_idle_zero("abort");
                    x_m = 64'd0;
                    @(posedge clk);
                    #1 reset = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        chk("abort_nodone", 64'(done), 64'd0);
                        chk("abort_rand", rand_out, 64'd0);
                    end
                    return;
                end
                chk("scan_busy", 64'(busy), 64'd1);
                chk("scan_done", 64'(done), 64'd0);
                chk("scan_shamt", 64'(sh_amt), 64'(i));
                chk("scan_shin", sh_in, xu);
                if (n == disturb) begin
                    start = 1'b1; seed_load = 1'b1; seed = ~xu;
                end
                @(posedge clk);
                #1;
                start = 1'b0; seed_load = 1'b0;
                n++;
            end
        end
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_rand", rand_out, exp);
        @(posedge clk);
        @(negedge clk);
        chk("post_done", 64'(done), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_rand", rand_out, exp);
        x_m = exp;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 64'd1, 64'd5, 64'd3, 64'd8};
        vecs[1] = '{1'b0, 64'd0, 64'd5, 64'd3, 64'd43};
        vecs[2] = '{1'b0, 64'd0, 64'd0, 64'h1234, 64'h1234};
        vecs[3] = '{1'b1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{1'b1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[5] = '{1'b1, 64'd1, 64'd6364136223846793005, 64'd1442695040888963407,
                    64'd7806831264735756412};

        reset = 1'b1; start = 1'b0; seed_load = 1'b0;
        seed = '0; mult_a = '0; incr_c = '0;
        x_m = 64'd0;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i])
            do_step(vecs[i].do_seed, vecs[i].seed, vecs[i].a, vecs[i].c, vecs[i].exp, -1, -1);

        // a = 2^63 with odd x keeps only bit 63
        do_step(1'b1, 64'd7, 64'h8000_0000_0000_0000, 64'd0, 64'h8000_0000_0000_0000, -1, -1);

        // Reset mid-idle clears state and outputs
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_zero("idle_reset");
        x_m = 64'd0;
        @(posedge clk);
        #1 reset = 1'b0;
        do_step(1'b0, 64'd0, 64'd3, 64'd5, 64'd5, -1, -1);

        // Random steps against the arithmetic model
        for (int t = 0; t < 20; t++) begin
            logic        sl;
            logic [63:0] sd, a, c, xu;
            sl = 1'($urandom);
            sd = {$urandom, $urandom};
            a  = ($urandom_range(0, 4) == 0) ? 64'd0 : {$urandom, $urandom};
            c  = {$urandom, $urandom};
            xu = sl ? sd : x_m;
            do_step(sl, sd, a, c, a * xu + c, -1, -1);
        end

        // start/seed_load while busy are ignored
        do_step(1'b1, 64'd9, 64'hFF, 64'd11, 64'd9 * 64'hFF + 64'd11, 2, -1);

        // Reset on the 3rd SCAN cycle aborts the step, then the next step sees x=0
        do_step(1'b1, 64'd77, 64'hFF, 64'd1, 64'd0, -1, 2);
        do_step(1'b0, 64'd0, 64'd6, 64'd4, 64'd4, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
